// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM master blocks: read FSM states and the
// full-word byte enable.
package avalon_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} rd_state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/avalon_read_arbiter_if.sv
// Requester-side and Avalon-side signals of the two-way read arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface avalon_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    logic              read;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        input  req_valid, req_addr0, req_addr1,
        input  waitrequest, readdata, readdatavalid,
        output req_ready, rsp_valid, rsp_data,
        output read, address, byteenable
    );

    modport slave (
        output req_valid, req_addr0, req_addr1,
        output waitrequest, readdata, readdatavalid,
        input  req_ready, rsp_valid, rsp_data,
        input  read, address, byteenable
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision. A lone requester always wins; when both
// ask, prio names the winner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt,
    output logic       any
);

    assign any = |req;
    assign gnt = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/avalon_read_arbiter.sv
// Shares one Avalon-MM read master between two requesters, one read in flight
// at a time, round-robin on contention. All outputs are registered.
module avalon_read_arbiter
    import avalon_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_read_arbiter_if.master bus,
    output logic                  busy
);

    rd_state_t state;
    logic      gnt;
    logic      prio;
    logic      arb_gnt;
    logic      arb_any;

    rr_arb2 u_arb (
        .req  (bus.req_valid),
        .prio (prio),
        .gnt  (arb_gnt),
        .any  (arb_any)
    );

    // Completion can happen in ISSUE (zero-latency slave) or WAIT_DATA; both
    // hand the word back and pass priority to the other requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            prio           <= 1'b0;
            busy           <= 1'b0;
            bus.read       <= 1'b0;
            bus.byteenable <= 4'b0000;
            bus.address    <= {ADDR_W{1'b0}};
            bus.req_ready  <= 2'b00;
            bus.rsp_valid  <= 2'b00;
            bus.rsp_data   <= {DATA_W{1'b0}};
        end else begin
            bus.req_ready <= 2'b00;
            bus.rsp_valid <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt            <= arb_gnt;
                        bus.address    <= arb_gnt ? bus.req_addr1 : bus.req_addr0;
                        bus.req_ready  <= onehot2(arb_gnt);
                        bus.read       <= 1'b1;
                        bus.byteenable <= BE_ALL;
                        busy           <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.waitrequest) begin
                        bus.read       <= 1'b0;
                        bus.byteenable <= 4'b0000;
                        if (bus.readdatavalid) begin
                            bus.rsp_data  <= bus.readdata;
                            bus.rsp_valid <= onehot2(gnt);
                            prio          <= ~gnt;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (bus.readdatavalid) begin
                        bus.rsp_data  <= bus.readdata;
                        bus.rsp_valid <= onehot2(gnt);
                        prio          <= ~gnt;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_read_arbiter.sv
// Self-checking bench for avalon_read_arbiter: scripted vector table, hand-written
// contention and reset sequences, then randomized traffic against a transaction model.
module tb_avalon_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    int vectors = 0;
    int miscompares = 0;

    avalon_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic        wr;
        logic        rdv;
        logic [31:0] rdata;
        logic [1:0]  ready;
        logic        read;
        logic [1:0]  rspv;
        logic        bsy;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic [1:0] rv, input logic wr, input logic rdv,
                                input logic [31:0] rdata, input logic [1:0] ready,
                                input logic read, input logic [1:0] rspv, input logic bsy,
                                input logic [31:0] addr, input logic [31:0] data);
        vec_t v;
        v.rv = rv; v.wr = wr; v.rdv = rdv; v.rdata = rdata; v.ready = ready;
        v.read = read; v.rspv = rspv; v.bsy = bsy; v.addr = addr; v.data = data;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] rv, input logic wr, input logic rdv,
                                 input logic [31:0] rdata);
        bus.req_valid     = rv;
        bus.waitrequest   = wr;
        bus.readdatavalid = rdv;
        bus.readdata      = rdata;
    endtask

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] e_ready, input logic e_read,
                               input logic [1:0] e_rspv, input logic e_busy,
                               input logic [31:0] e_addr, input logic chk_addr,
                               input logic [31:0] e_data);
        checkField({tag, ".req_ready"}, 32'(bus.req_ready), 32'(e_ready));
        checkField({tag, ".read"}, 32'(bus.read), 32'(e_read));
        checkField({tag, ".byteenable"}, 32'(bus.byteenable), e_read ? 32'hF : 32'h0);
        checkField({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(e_rspv));
        checkField({tag, ".busy"}, 32'(busy), 32'(e_busy));
        checkField({tag, ".rsp_data"}, bus.rsp_data, e_data);
        if (chk_addr)
            checkField({tag, ".address"}, bus.address, e_addr);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("reset", 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] prev_data;
        logic [31:0] m_addr[2];
        logic [31:0] cur_addr;
        logic [31:0] m_data;
        logic [1:0]  rv, e_ready, e_rspv;
        logic        wr, rdv, g, m_prio, outstanding, accepted, fin;
        logic [31:0] rdata;
        int          lat, cnt0, cnt1;
        int          order[4] = '{0, 1, 0, 1};

        bus.req_addr0 = 32'h100;
        bus.req_addr1 = 32'h2C;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);

        tbl[0]  = mk(2'b01, 0, 0, 32'h0,        2'b01, 1, 2'b00, 1, 32'h100, 32'h0);
        tbl[1]  = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'h0);
        tbl[2]  = mk(2'b00, 0, 1, 32'hDEADBEEF, 2'b00, 0, 2'b01, 0, 32'h0,   32'hDEADBEEF);
        tbl[3]  = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 2'b00, 0, 32'h0,   32'hDEADBEEF);
        tbl[4]  = mk(2'b10, 0, 0, 32'h0,        2'b10, 1, 2'b00, 1, 32'h2C,  32'hDEADBEEF);
        tbl[5]  = mk(2'b00, 1, 0, 32'h0,        2'b00, 1, 2'b00, 1, 32'h2C,  32'hDEADBEEF);
        tbl[6]  = mk(2'b00, 1, 0, 32'h0,        2'b00, 1, 2'b00, 1, 32'h2C,  32'hDEADBEEF);
        tbl[7]  = mk(2'b00, 1, 0, 32'h0,        2'b00, 1, 2'b00, 1, 32'h2C,  32'hDEADBEEF);
        tbl[8]  = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'hDEADBEEF);
        tbl[9]  = mk(2'b00, 0, 1, 32'h12345678, 2'b00, 0, 2'b10, 0, 32'h0,   32'h12345678);
        tbl[10] = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 2'b00, 0, 32'h0,   32'h12345678);
        tbl[11] = mk(2'b01, 0, 0, 32'h0,        2'b01, 1, 2'b00, 1, 32'h100, 32'h12345678);
        tbl[12] = mk(2'b00, 0, 1, 32'hA5A50F0F, 2'b00, 0, 2'b01, 0, 32'h0,   32'hA5A50F0F);
        tbl[13] = mk(2'b10, 0, 0, 32'h0,        2'b10, 1, 2'b00, 1, 32'h2C,  32'hA5A50F0F);
        tbl[14] = mk(2'b00, 0, 1, 32'h0BADF00D, 2'b00, 0, 2'b10, 0, 32'h0,   32'h0BADF00D);
        tbl[15] = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 2'b00, 0, 32'h0,   32'h0BADF00D);
        tbl[16] = mk(2'b01, 0, 0, 32'h0,        2'b01, 1, 2'b00, 1, 32'h100, 32'h0BADF00D);
        tbl[17] = mk(2'b10, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'h0BADF00D);
        tbl[18] = mk(2'b10, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'h0BADF00D);
        tbl[19] = mk(2'b10, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'h0BADF00D);
        tbl[20] = mk(2'b10, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'h0BADF00D);
        tbl[21] = mk(2'b10, 0, 0, 32'h0,        2'b00, 0, 2'b00, 1, 32'h0,   32'h0BADF00D);
        tbl[22] = mk(2'b10, 0, 1, 32'hCAFE0001, 2'b00, 0, 2'b01, 0, 32'h0,   32'hCAFE0001);
        tbl[23] = mk(2'b10, 0, 0, 32'h0,        2'b10, 1, 2'b00, 1, 32'h2C,  32'hCAFE0001);
        tbl[24] = mk(2'b00, 0, 1, 32'h00000042, 2'b00, 0, 2'b10, 0, 32'h0,   32'h00000042);
        tbl[25] = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 2'b00, 0, 32'h0,   32'h00000042);

        doReset();

        for (int k = 0; k < 26; k++) begin
            applyStimulus(tbl[k].rv, tbl[k].wr, tbl[k].rdv, tbl[k].rdata);
            tick();
            checkOutput($sformatf("table[%0d]", k), tbl[k].ready, tbl[k].read, tbl[k].rspv,
                        tbl[k].bsy, tbl[k].addr, tbl[k].read, tbl[k].data);
        end

        // Both requesters held valid from reset: grants must alternate 0,1,0,1.
        doReset();
        cnt0 = 0;
        cnt1 = 0;
        prev_data = 32'h0;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
            tick();
            checkOutput($sformatf("contend[%0d].grant", t), order[t] == 1 ? 2'b10 : 2'b01, 1'b1,
                        2'b00, 1'b1, order[t] == 1 ? 32'h2C : 32'h100, 1'b1, prev_data);
            applyStimulus(2'b11, 1'b0, 1'b1, 32'h1000 + 32'(t));
            tick();
            prev_data = 32'h1000 + 32'(t);
            checkOutput($sformatf("contend[%0d].rsp", t), 2'b00, 1'b0,
                        order[t] == 1 ? 2'b10 : 2'b01, 1'b0, 32'h0, 1'b0, prev_data);
            if (bus.rsp_valid[0]) cnt0++;
            if (bus.rsp_valid[1]) cnt1++;
        end
        checkField("contend.pulses0", 32'(cnt0), 32'd2);
        checkField("contend.pulses1", 32'(cnt1), 32'd2);

        // Move priority to requester 1, then reset while its read waits for data.
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("midrst.grant0", 2'b01, 1'b1, 2'b00, 1'b1, 32'h100, 1'b1, prev_data);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h77);
        tick();
        checkOutput("midrst.rsp0", 2'b00, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 32'h77);
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("midrst.grant1", 2'b10, 1'b1, 2'b00, 1'b1, 32'h2C, 1'b1, 32'h77);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("midrst.wait", 2'b00, 1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h77);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst.async", 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        reset_n = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h5555AAAA);
        tick();
        checkOutput("midrst.stale", 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0);
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("midrst.regrant", 2'b01, 1'b1, 2'b00, 1'b1, 32'h100, 1'b1, 32'h0);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h99);
        tick();
        checkOutput("midrst.rsp", 2'b00, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 32'h99);

        // Randomized traffic against a transaction-level model: one read in
        // flight, lone requester wins, contention goes to whoever did not win last.
        doReset();
        m_prio = 1'b0;
        outstanding = 1'b0;
        accepted = 1'b0;
        g = 1'b0;
        lat = 0;
        m_data = 32'h0;
        cur_addr = 32'h0;
        rv = 2'b00;
        e_ready = 2'b00;
        m_addr[0] = 32'h100;
        m_addr[1] = 32'h2C;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (e_ready[i]) begin
                    rv[i] = 1'b0;
                end else if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    m_addr[i] = $urandom;
                end
            end
            wr = 1'b0;
            rdv = 1'b0;
            rdata = $urandom;
            if (outstanding && !accepted) begin
                wr = ($urandom_range(0, 2) == 0);
                if (!wr) begin
                    if ($urandom_range(0, 2) == 0) rdv = 1'b1;
                    else lat = $urandom_range(0, 4);
                end
            end else if (outstanding) begin
                if (lat == 0) rdv = 1'b1;
                else lat--;
            end else begin
                rdv = ($urandom_range(0, 7) == 0);
            end
            bus.req_addr0 = m_addr[0];
            bus.req_addr1 = m_addr[1];
            applyStimulus(rv, wr, rdv, rdata);

            e_ready = 2'b00;
            e_rspv = 2'b00;
            fin = 1'b0;
            if (!outstanding) begin
                if (rv != 2'b00) begin
                    g = (rv == 2'b11) ? m_prio : rv[1];
                    outstanding = 1'b1;
                    accepted = 1'b0;
                    cur_addr = m_addr[g];
                    e_ready[g] = 1'b1;
                end
            end else if (!accepted) begin
                if (!wr) begin
                    accepted = 1'b1;
                    fin = rdv;
                end
            end else begin
                fin = rdv;
            end
            if (fin) begin
                e_rspv[g] = 1'b1;
                m_data = rdata;
                m_prio = ~g;
                outstanding = 1'b0;
            end
            tick();
            checkOutput("rand", e_ready, outstanding && !accepted, e_rspv, outstanding,
                        cur_addr, outstanding && !accepted, m_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
